// File: rtl/chan_stat_rmw_pkg.sv
// Shared op encodings, FSM states and op classification helpers for the channel stats engine.
// No timing of its own; the stage record lives in the engine because its widths are parameters.
package chan_stat_rmw_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_READ  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RDCLR = 2'b11
    } op_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Every op except a plain READ writes its result back one cycle after read data lands.
    function automatic logic opWrites(input op_t op);
        return op != OP_READ;
    endfunction

    function automatic logic opResponds(input op_t op);
        return (op == OP_READ) || (op == OP_RDCLR);
    endfunction

endpackage

// File: rtl/chan_stat_rmw.sv
// Per-channel counter read-modify-write engine driving one 1RW SRAM-wrapper requestor port.
// Latency: read issued on accept, response at accept+2, write-back and overflow pulse at accept+3.
// Backpressure: updRdy low during table init and in any write-back cycle; responses are never stalled.
module chan_stat_rmw
    import chan_stat_rmw_pkg::*;
#(
    parameter int RAM_DEPTH  = 16,
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clockCore,
    input  logic                  resetCore,
    input  logic                  updVld,
    output logic                  updRdy,
    input  logic [1:0]            updOp,
    input  logic [ADDR_WIDTH-1:0] updChan,
    input  logic [LEN_WIDTH-1:0]  updLen,
    output logic                  rspVld,
    output logic [ADDR_WIDTH-1:0] rspChan,
    output logic [RAM_WIDTH-1:0]  rspData,
    output logic                  rspOvf,
    output logic                  initDone,
    output logic                  rdEn,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [RAM_WIDTH-1:0]  wrData,
    input  logic [RAM_WIDTH-1:0]  rdData
);

    localparam int PAD_WIDTH = RAM_WIDTH + 1 - LEN_WIDTH;

    typedef struct packed {
        logic                  valid;
        op_t                   op;
        logic [ADDR_WIDTH-1:0] chan;
        logic [LEN_WIDTH-1:0]  len;
    } stage_t;

    state_t                state;
    state_t                stateNext;
    logic [ADDR_WIDTH-1:0] initCnt;

    stage_t                s1;
    stage_t                s2;
    logic                  s3Valid;
    op_t                   s3Op;
    logic [ADDR_WIDTH-1:0] s3Chan;
    logic [RAM_WIDTH-1:0]  s3Result;
    logic                  s3Carry;

    logic                  accept;
    logic                  s3Write;
    logic [RAM_WIDTH:0]    sum;
    logic [RAM_WIDTH:0]    nextVal;

    // A pending write-back owns the single SRAM port, so no read may be issued alongside it.
    assign s3Write  = s3Valid && opWrites(s3Op);
    assign updRdy   = (state == ST_RUN) && !s3Write;
    assign accept   = updVld && updRdy;
    assign rdEn     = accept;
    assign rdAddr   = accept ? updChan : '0;
    assign initDone = (state == ST_RUN);

    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            state   <= ST_INIT;
            initCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_INIT) begin
                initCnt <= initCnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        if ((state == ST_INIT) && (initCnt == ADDR_WIDTH'(RAM_DEPTH - 1))) begin
            stateNext = ST_RUN;
        end
    end

    // Same-channel hazards are resolved by the wrapper's bypass; the old value is taken as-is.
    always_comb begin
        sum     = {1'b0, rdData} + {{PAD_WIDTH{1'b0}}, s2.len};
        nextVal = '0;
        if (s2.op == OP_ADD) begin
            nextVal = sum;
        end
    end

    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            s1       <= '0;
            s2       <= '0;
            s3Valid  <= 1'b0;
            s3Op     <= OP_ADD;
            s3Chan   <= '0;
            s3Result <= '0;
            s3Carry  <= 1'b0;
        end else begin
            s1.valid <= accept;
            s1.op    <= op_t'(updOp);
            s1.chan  <= updChan;
            s1.len   <= updLen;
            s2       <= s1;
            s3Valid  <= s2.valid;
            s3Op     <= s2.op;
            s3Chan   <= s2.chan;
            {s3Carry, s3Result} <= nextVal;
        end
    end

    assign rspVld  = s2.valid && opResponds(s2.op);
    assign rspChan = rspVld ? s2.chan : '0;
    assign rspData = rspVld ? rdData : '0;
    assign rspOvf  = s3Valid && (s3Op == OP_ADD) && s3Carry;

    // Table zeroing takes the write port until the last entry is cleared.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        if (state == ST_INIT) begin
            wrEn   = 1'b1;
            wrAddr = initCnt;
        end else if (s3Write) begin
            wrEn   = 1'b1;
            wrAddr = s3Chan;
            wrData = s3Result;
        end
    end

endmodule

// File: tb/tb_chan_stat_rmw.sv
// Bench for chan_stat_rmw: a 32-bit and a 16-bit counter build share one stimulus stream,
// each behind a behavioural 2-cycle SRAM wrapper with same-cycle write bypass.
module tb_chan_stat_rmw;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [1:0] ADD   = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] CLR   = 2'b10;
    localparam logic [1:0] RDCLR = 2'b11;

    typedef struct {
        int          due;
        logic [3:0]  chan;
        logic [31:0] d32;
        logic [15:0] d16;
    } exp_t;

    logic          clockCore;
    logic          resetCore;
    logic          updVld;
    logic [1:0]    updOp;
    logic [AW-1:0] updChan;
    logic [15:0]   updLen;

    logic          updRdy32, rspVld32, rspOvf32, initDone32, rdEn32, wrEn32;
    logic [AW-1:0] rspChan32, rdAddr32, wrAddr32;
    logic [31:0]   rspData32, wrData32, rdData32;
    logic          updRdy16, rspVld16, rspOvf16, initDone16, rdEn16, wrEn16;
    logic [AW-1:0] rspChan16, rdAddr16, wrAddr16;
    logic [15:0]   rspData16, wrData16, rdData16;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   running = 1'b0;

    exp_t        rspQ[$];
    exp_t        wrQ[$];
    bit          blocked[int];
    bit          ovf32[int];
    bit          ovf16[int];
    logic [31:0] m32[DEPTH];
    logic [15:0] m16[DEPTH];

    chan_stat_rmw dut32 (
        .clockCore(clockCore), .resetCore(resetCore),
        .updVld(updVld), .updRdy(updRdy32), .updOp(updOp), .updChan(updChan), .updLen(updLen),
        .rspVld(rspVld32), .rspChan(rspChan32), .rspData(rspData32), .rspOvf(rspOvf32),
        .initDone(initDone32), .rdEn(rdEn32), .rdAddr(rdAddr32),
        .wrEn(wrEn32), .wrAddr(wrAddr32), .wrData(wrData32), .rdData(rdData32)
    );

    chan_stat_rmw #(.RAM_WIDTH(16)) dut16 (
        .clockCore(clockCore), .resetCore(resetCore),
        .updVld(updVld), .updRdy(updRdy16), .updOp(updOp), .updChan(updChan), .updLen(updLen),
        .rspVld(rspVld16), .rspChan(rspChan16), .rspData(rspData16), .rspOvf(rspOvf16),
        .initDone(initDone16), .rdEn(rdEn16), .rdAddr(rdAddr16),
        .wrEn(wrEn16), .wrAddr(wrAddr16), .wrData(wrData16), .rdData(rdData16)
    );

    initial clockCore = 1'b0;
    always #5 clockCore = ~clockCore;
    always @(posedge clockCore) cyc <= cyc + 1;

    // SRAM wrapper models: scrambled while in reset so only the engine's init can zero them.
    logic [31:0]   mem32[DEPTH];
    logic [15:0]   mem16[DEPTH];
    logic [1:0]    pend32, pend16;
    logic [AW-1:0] a32d1, a32d2, a16d1, a16d2;

    always @(posedge clockCore) begin
        if (!resetCore) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem32[i] <= $urandom;
                mem16[i] <= 16'($urandom);
            end
        end else begin
            if (wrEn32) mem32[wrAddr32] <= wrData32;
            if (wrEn16) mem16[wrAddr16] <= wrData16;
        end
        pend32 <= {pend32[0], rdEn32};
        pend16 <= {pend16[0], rdEn16};
        a32d1  <= rdAddr32;
        a32d2  <= a32d1;
        a16d1  <= rdAddr16;
        a16d2  <= a16d1;
    end

    always_comb begin
        rdData32 = 32'hDEAD_BEEF;
        if (pend32[1]) rdData32 = (wrEn32 && wrAddr32 == a32d2) ? wrData32 : mem32[a32d2];
    end

    always_comb begin
        rdData16 = 16'hBEEF;
        if (pend16[1]) rdData16 = (wrEn16 && wrAddr16 == a16d2) ? wrData16 : mem16[a16d2];
    end

    // Reference: ops take effect in acceptance order on plain counter arrays.
    task automatic modelApply(input logic [1:0] op, input logic [3:0] ch, input logic [15:0] len, input int c);
        logic [32:0] s32;
        logic [16:0] s16;
        exp_t        e;
        e.chan = ch;
        e.d32  = m32[ch];
        e.d16  = m16[ch];
        e.due  = c + 2;
        if (op == ADD) begin
            s32 = {1'b0, m32[ch]} + {17'd0, len};
            s16 = {1'b0, m16[ch]} + {1'b0, len};
            m32[ch] = s32[31:0];
            m16[ch] = s16[15:0];
            if (s32[32]) ovf32[c + 3] = 1'b1;
            if (s16[16]) ovf16[c + 3] = 1'b1;
        end
        if (op == READ || op == RDCLR) rspQ.push_back(e);
        if (op == CLR || op == RDCLR) begin
            m32[ch] = '0;
            m16[ch] = '0;
        end
        if (op != READ) begin
            e.due = c + 3;
            e.d32 = m32[ch];
            e.d16 = m16[ch];
            wrQ.push_back(e);
            blocked[c + 3] = 1'b1;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance with updVld dropped.
    task automatic issue(input logic [1:0] op, input logic [3:0] ch, input logic [15:0] len, output int acc);
        int budget;
        budget  = 0;
        updVld  = 1'b1;
        updOp   = op;
        updChan = ch;
        updLen  = len;
        #1;
        while (!updRdy32 && budget < 16) begin
            @(negedge clockCore);
            #1;
            budget++;
        end
        checks++;
        if (!updRdy32) begin
            errors++;
            $display("FAIL accept_timeout op=%0d chan=%0d updRdy=%b required 1 within 16 cycles", op, ch, updRdy32);
            acc = -1;
        end else begin
            acc = cyc;
            modelApply(op, ch, len, cyc);
        end
        @(negedge clockCore);
        updVld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clockCore);
    endtask

    task automatic checkInit();
        for (int i = 0; i < DEPTH; i++) begin
            #2;
            checks++;
            if (!(wrEn32 && wrEn16 && wrAddr32 == AW'(i) && wrAddr16 == AW'(i) && wrData32 == 0 && wrData16 == 0 &&
                  !rdEn32 && !rdEn16 && !updRdy32 && !updRdy16 && !initDone32 && !initDone16 &&
                  !rspVld32 && !rspVld16 && !rspOvf32 && !rspOvf16)) begin
                errors++;
                $display("FAIL init_write[%0d] wrEn=%b/%b wrAddr=%0d/%0d wrData=%0h/%0h rdEn=%b updRdy=%b initDone=%b rspVld=%b rspOvf=%b required wrEn=1 wrAddr=%0d wrData=0 others 0",
                         i, wrEn32, wrEn16, wrAddr32, wrAddr16, wrData32, wrData16, rdEn32, updRdy32, initDone32, rspVld32, rspOvf32, i);
            end
            @(negedge clockCore);
        end
        running = 1'b1;
        #2;
        checks++;
        if (!(initDone32 && initDone16 && updRdy32 && updRdy16 && !wrEn32 && !wrEn16)) begin
            errors++;
            $display("FAIL init_done initDone=%b/%b updRdy=%b/%b wrEn=%b/%b required 1 1 0",
                     initDone32, initDone16, updRdy32, updRdy16, wrEn32, wrEn16);
        end
        @(negedge clockCore);
    endtask

    // Called at a falling edge so the low level is sampled by the very next rising edge.
    task automatic doReset();
        running   = 1'b0;
        resetCore = 1'b0;
        updVld    = 1'b0;
        rspQ.delete();
        wrQ.delete();
        blocked.delete();
        ovf32.delete();
        ovf16.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m32[i] = '0;
            m16[i] = '0;
        end
        @(negedge clockCore);
        resetCore = 1'b1;
        checkInit();
    endtask

    // Monitor: pops the scoreboard whenever the engine presents a response or write-back.
    initial begin
        exp_t e;
        bit   expRdy;
        bit   eo32;
        bit   eo16;
        forever begin
            @(negedge clockCore);
            #2;
            if (running) begin
                checks++;
                if ((rdEn32 && wrEn32) || (rdEn16 && wrEn16)) begin
                    errors++;
                    $display("FAIL port_overlap cyc=%0d rdEn=%b/%b wrEn=%b/%b required never both", cyc, rdEn32, rdEn16, wrEn32, wrEn16);
                end
                expRdy = !blocked.exists(cyc);
                checks++;
                if (updRdy32 !== expRdy || updRdy16 !== expRdy) begin
                    errors++;
                    $display("FAIL upd_rdy cyc=%0d updRdy=%b/%b required %b", cyc, updRdy32, updRdy16, expRdy);
                end
                eo32 = ovf32.exists(cyc);
                eo16 = ovf16.exists(cyc);
                checks++;
                if (rspOvf32 !== eo32 || rspOvf16 !== eo16) begin
                    errors++;
                    $display("FAIL rsp_ovf cyc=%0d rspOvf=%b/%b required %b/%b", cyc, rspOvf32, rspOvf16, eo32, eo16);
                end
                while (rspQ.size() > 0 && rspQ[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing cyc=%0d chan=%0d rspVld=0 required 1 at cyc %0d", cyc, rspQ[0].chan, rspQ[0].due);
                    void'(rspQ.pop_front());
                end
                if (rspVld32 || rspVld16) begin
                    checks++;
                    if (rspQ.size() == 0 || rspQ[0].due != cyc) begin
                        errors++;
                        $display("FAIL rsp_unexpected cyc=%0d rspVld=%b/%b chan=%0d required rspVld 0", cyc, rspVld32, rspVld16, rspChan32);
                    end else begin
                        e = rspQ.pop_front();
                        if (!(rspVld32 && rspVld16 && rspChan32 == e.chan && rspChan16 == e.chan &&
                              rspData32 == e.d32 && rspData16 == e.d16)) begin
                            errors++;
                            $display("FAIL rsp_data cyc=%0d vld=%b/%b chan=%0d/%0d data=%0h/%0h required chan=%0d data=%0h/%0h",
                                     cyc, rspVld32, rspVld16, rspChan32, rspChan16, rspData32, rspData16, e.chan, e.d32, e.d16);
                        end
                    end
                end
                while (wrQ.size() > 0 && wrQ[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_missing cyc=%0d chan=%0d wrEn=0 required 1 at cyc %0d", cyc, wrQ[0].chan, wrQ[0].due);
                    void'(wrQ.pop_front());
                end
                if (wrEn32 || wrEn16) begin
                    checks++;
                    if (wrQ.size() == 0 || wrQ[0].due != cyc) begin
                        errors++;
                        $display("FAIL wr_unexpected cyc=%0d wrEn=%b/%b wrAddr=%0d required wrEn 0", cyc, wrEn32, wrEn16, wrAddr32);
                    end else begin
                        e = wrQ.pop_front();
                        if (!(wrEn32 && wrEn16 && wrAddr32 == e.chan && wrAddr16 == e.chan &&
                              wrData32 == e.d32 && wrData16 == e.d16)) begin
                            errors++;
                            $display("FAIL wr_data cyc=%0d wrEn=%b/%b addr=%0d/%0d data=%0h/%0h required addr=%0d data=%0h/%0h",
                                     cyc, wrEn32, wrEn16, wrAddr32, wrAddr16, wrData32, wrData16, e.chan, e.d32, e.d16);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d simulation did not finish, required completion", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int ac[5];
        int expOff[5] = '{0, 1, 2, 6, 7};
        logic [1:0]  op;
        logic [3:0]  ch;
        logic [15:0] len;

        resetCore = 1'b0;
        updVld    = 1'b0;
        updOp     = '0;
        updChan   = '0;
        updLen    = '0;
        doReset();

        issue(ADD, 4'd3, 16'd100, acc);
        idle(3);
        issue(READ, 4'd3, 16'd0, acc);
        idle(4);

        for (int i = 0; i < 5; i++) issue(ADD, 4'd5, 16'd1, ac[i]);
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (ac[i] - ac[0] != expOff[i]) begin
                errors++;
                $display("FAIL accept_pattern[%0d] offset=%0d required %0d", i, ac[i] - ac[0], expOff[i]);
            end
        end
        issue(READ, 4'd5, 16'd0, acc);
        idle(4);

        issue(ADD, 4'd2, 16'hFFFF, acc);
        issue(ADD, 4'd2, 16'd2, acc);
        issue(READ, 4'd2, 16'd0, acc);
        idle(4);

        issue(ADD, 4'd7, 16'd42, acc);
        issue(RDCLR, 4'd7, 16'd0, acc);
        issue(READ, 4'd7, 16'd0, acc);
        issue(CLR, 4'd7, 16'd0, acc);
        issue(READ, 4'd0, 16'd0, acc);
        idle(4);

        for (int n = 0; n < 300; n++) begin
            op  = 2'($urandom_range(0, 3));
            ch  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            issue(op, ch, len, acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        issue(ADD, 4'd1, 16'd9, acc);
        doReset();
        issue(READ, 4'd1, 16'd0, acc);
        issue(READ, 4'd9, 16'd0, acc);
        idle(8);

        checks++;
        if (rspQ.size() != 0 || wrQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending rsp=%0d wr=%0d required 0 0", rspQ.size(), wrQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
